// File: rtl/pcie_msi_irq_gen_if.sv
// MSI handshake bundle between the interrupt generator and the PCIe core
// configuration interrupt port. The generator uses the master modport, the
// core (or a model of it) uses the slave modport.
interface pcie_msi_irq_gen_if;
    logic [3:0]  cfg_interrupt_msi_enable;
    logic [11:0] cfg_interrupt_msi_mmenable;
    logic [31:0] cfg_interrupt_msi_int;
    logic        cfg_interrupt_msi_sent;
    logic        cfg_interrupt_msi_fail;
    logic [3:0]  cfg_interrupt_msi_select;
    logic [3:0]  cfg_interrupt_msi_function_number;
    logic [31:0] cfg_interrupt_msi_pending_status;

    modport master (
        input  cfg_interrupt_msi_enable,
        input  cfg_interrupt_msi_mmenable,
        input  cfg_interrupt_msi_sent,
        input  cfg_interrupt_msi_fail,
        output cfg_interrupt_msi_int,
        output cfg_interrupt_msi_select,
        output cfg_interrupt_msi_function_number,
        output cfg_interrupt_msi_pending_status
    );

    modport slave (
        output cfg_interrupt_msi_enable,
        output cfg_interrupt_msi_mmenable,
        output cfg_interrupt_msi_sent,
        output cfg_interrupt_msi_fail,
        input  cfg_interrupt_msi_int,
        input  cfg_interrupt_msi_select,
        input  cfg_interrupt_msi_function_number,
        input  cfg_interrupt_msi_pending_status
    );
endinterface

// File: rtl/pcie_msi_irq_gen.sv
// MSI interrupt generator: collects one-cycle request pulses into a pending
// register, serves them round-robin as one-hot MSI pulses, waits for the
// core's sent/fail strobe, and retries failed or timed-out vectors after a
// holdoff period.
module pcie_msi_irq_gen #(
    parameter int IRQ_COUNT   = 32,
    parameter int RETRY_DELAY = 16,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IRQ_COUNT-1:0] irq_req,
    output logic                 busy,
    pcie_msi_irq_gen_if.master   msi
);
    localparam int IDX_W = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(IRQ_COUNT - 1);
    localparam logic [15:0]      TMO_LOAD  = 16'(TIMEOUT);
    localparam logic [7:0]       HOLD_LOAD = 8'(RETRY_DELAY);

    logic [1:0]           state_q, state_d;
    logic [IRQ_COUNT-1:0] pending_q, pending_d;
    logic [IDX_W-1:0]     cur_q, cur_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [15:0]          tmo_q, tmo_d;
    logic [7:0]           hold_q, hold_d;
    logic [31:0]          msi_int_q, msi_int_d;

    logic                 sel_found;
    logic [IDX_W-1:0]     sel_idx;
    int                   cand;
    logic [2:0]           mm;
    logic [4:0]           mm_mask;
    logic [4:0]           msi_bit;

    // Upper enable/mmenable bits belong to other functions and are not used here.
    logic unused_cfg;
    assign unused_cfg = ^{msi.cfg_interrupt_msi_enable[3:1],
                          msi.cfg_interrupt_msi_mmenable[11:3]};

    // Round-robin search: first pending vector at or after last_served+1, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int i = 0; i < IRQ_COUNT; i++) begin
            cand = int'(last_q) + 1 + i;
            if (cand >= IRQ_COUNT) begin
                cand = cand - IRQ_COUNT;
            end
            if (!sel_found && pending_q[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(cand);
            end
        end
    end

    // Fold the selected vector onto the number of MSI vectors the host granted.
    always_comb begin
        mm      = (msi.cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5
                                                               : msi.cfg_interrupt_msi_mmenable[2:0];
        mm_mask = 5'((6'd1 << mm) - 6'd1);
        msi_bit = 5'(sel_idx) & mm_mask;
    end

    // Next-state logic for the FSM, counters and pending register.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        cur_d     = cur_q;
        last_d    = last_q;
        tmo_d     = tmo_q;
        hold_d    = hold_q;
        msi_int_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (msi.cfg_interrupt_msi_enable[0] && sel_found) begin
                    cur_d     = sel_idx;
                    msi_int_d = 32'd1 << msi_bit;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = TMO_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Fail outranks sent; a timeout is treated exactly like a fail.
                if (msi.cfg_interrupt_msi_fail) begin
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else if (msi.cfg_interrupt_msi_sent) begin
                    pending_d[cur_q] = 1'b0;
                    last_d           = cur_q;
                    state_d          = ST_IDLE;
                end else if (tmo_q <= 16'd1) begin
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end else begin
                    tmo_d = tmo_q - 16'd1;
                end
            end
            ST_HOLD: begin
                if (hold_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // New requests are merged last so a request coinciding with sent survives.
        pending_d = pending_d | irq_req;
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            cur_q     <= '0;
            last_q    <= LAST_RST;
            tmo_q     <= '0;
            hold_q    <= '0;
            msi_int_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            msi_int_q <= msi_int_d;
        end
    end

    logic [31:0] pending_ext;
    for (genvar gi = 0; gi < 32; gi++) begin : g_pend
        if (gi < IRQ_COUNT) begin : g_used
            assign pending_ext[gi] = pending_q[gi];
        end else begin : g_pad
            assign pending_ext[gi] = 1'b0;
        end
    end

    assign msi.cfg_interrupt_msi_int             = msi_int_q;
    assign msi.cfg_interrupt_msi_select          = 4'd0;
    assign msi.cfg_interrupt_msi_function_number = 4'd0;
    assign msi.cfg_interrupt_msi_pending_status  = pending_ext;
    assign busy                                  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_pcie_msi_irq_gen.sv
// Directed bench for pcie_msi_irq_gen: a table of single-vector requests
// followed by hand-written multi-cycle sequences.
module tb_pcie_msi_irq_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq_req;
    logic        busy;

    pcie_msi_irq_gen_if msi();

    pcie_msi_irq_gen #(
        .IRQ_COUNT  (32),
        .RETRY_DELAY(16),
        .TIMEOUT    (1024)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_req(irq_req),
        .busy   (busy),
        .msi    (msi)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          vec;
        logic [2:0]  mm;
        logic [31:0] exp_int;
    } vec_t;

    vec_t tbl[7];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input int v);
        irq_req = 32'd1 << v;
        tick();
        irq_req = '0;
    endtask

    // Wait (bounded) for an MSI pulse and compare it.
    task automatic expect_msi(input logic [31:0] exp, input string name);
        int n = 0;
        while (msi.cfg_interrupt_msi_int == 32'd0 && n < 64) begin
            tick();
            n++;
        end
        check(name, msi.cfg_interrupt_msi_int, exp);
        $display("msi %s: int=0x%08h after %0d cycles", name, msi.cfg_interrupt_msi_int, n);
    endtask

    // From the ISSUE cycle: move into WAIT and acknowledge with sent.
    task automatic ack_sent();
        tick();
        msi.cfg_interrupt_msi_sent = 1'b1;
        tick();
        msi.cfg_interrupt_msi_sent = 1'b0;
    endtask

    // Hard stop if something hangs.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        tbl[0] = '{3,  3'd5, 32'h0000_0008};
        tbl[1] = '{6,  3'd1, 32'h0000_0001};
        tbl[2] = '{6,  3'd2, 32'h0000_0004};
        tbl[3] = '{31, 3'd5, 32'h8000_0000};
        tbl[4] = '{10, 3'd0, 32'h0000_0001};
        tbl[5] = '{13, 3'd7, 32'h0000_2000};
        tbl[6] = '{9,  3'd3, 32'h0000_0002};

        rst                            = 1'b1;
        irq_req                        = '0;
        msi.cfg_interrupt_msi_enable   = 4'h1;
        msi.cfg_interrupt_msi_mmenable = 12'd5;
        msi.cfg_interrupt_msi_sent     = 1'b0;
        msi.cfg_interrupt_msi_fail     = 1'b0;
        tick();
        tick();
        check("rst_int", msi.cfg_interrupt_msi_int, 32'd0);
        check("rst_pending", msi.cfg_interrupt_msi_pending_status, 32'd0);
        check("rst_busy", busy, 0);
        check("rst_select", msi.cfg_interrupt_msi_select, 0);
        check("rst_func", msi.cfg_interrupt_msi_function_number, 0);
        rst = 1'b0;
        tick();

        // Single requests with vector folding: exact 2-cycle latency, one-cycle pulse.
        for (int i = 0; i < 7; i++) begin
            msi.cfg_interrupt_msi_mmenable = {9'd0, tbl[i].mm};
            pulse_irq(tbl[i].vec);
            check($sformatf("tbl%0d_lat1", i), msi.cfg_interrupt_msi_int, 32'd0);
            tick();
            check($sformatf("tbl%0d_int", i), msi.cfg_interrupt_msi_int, tbl[i].exp_int);
            check($sformatf("tbl%0d_pend", i), msi.cfg_interrupt_msi_pending_status, 32'd1 << tbl[i].vec);
            $display("vec %0d mm %0d: int=0x%08h", tbl[i].vec, tbl[i].mm, msi.cfg_interrupt_msi_int);
            tick();
            check($sformatf("tbl%0d_oneshot", i), msi.cfg_interrupt_msi_int, 32'd0);
            msi.cfg_interrupt_msi_sent = 1'b1;
            tick();
            msi.cfg_interrupt_msi_sent = 1'b0;
            check($sformatf("tbl%0d_clr", i), msi.cfg_interrupt_msi_pending_status, 32'd0);
            check($sformatf("tbl%0d_busy", i), busy, 0);
        end
        msi.cfg_interrupt_msi_mmenable = 12'd5;

        // Round-robin: 1, 2, 5 then a late vector 0 after wrapping.
        irq_req = 32'h0000_0026;
        tick();
        irq_req = '0;
        expect_msi(32'h2, "rr_1");
        ack_sent();
        expect_msi(32'h4, "rr_2");
        ack_sent();
        expect_msi(32'h20, "rr_5");
        tick();
        irq_req                    = 32'h1;
        msi.cfg_interrupt_msi_sent = 1'b1;
        tick();
        irq_req                    = '0;
        msi.cfg_interrupt_msi_sent = 1'b0;
        expect_msi(32'h1, "rr_0");
        ack_sent();
        check("rr_pend", msi.cfg_interrupt_msi_pending_status, 32'd0);

        // Fail (together with sent) on vector 7, strobe during HOLD ignored, retry.
        pulse_irq(7);
        expect_msi(32'h80, "fail_first");
        tick();
        msi.cfg_interrupt_msi_sent = 1'b1;
        msi.cfg_interrupt_msi_fail = 1'b1;
        tick();
        msi.cfg_interrupt_msi_sent = 1'b0;
        msi.cfg_interrupt_msi_fail = 1'b0;
        n   = 0;
        bad = 0;
        while (msi.cfg_interrupt_msi_int == 32'd0 && n < 40) begin
            if (msi.cfg_interrupt_msi_pending_status[7] !== 1'b1 || (n < 16 && busy !== 1'b1)) bad++;
            msi.cfg_interrupt_msi_sent = (n == 3);
            tick();
            n++;
        end
        msi.cfg_interrupt_msi_sent = 1'b0;
        check("fail_held", bad, 0);
        check("fail_delay", n, 17);
        check("fail_reissue", msi.cfg_interrupt_msi_int, 32'h80);
        ack_sent();
        check("fail_clr", msi.cfg_interrupt_msi_pending_status, 32'd0);

        // Timeout on vector 4: 1024 WAIT + 16 HOLD + IDLE before reissue.
        pulse_irq(4);
        expect_msi(32'h10, "tmo_first");
        tick();
        n   = 0;
        bad = 0;
        while (msi.cfg_interrupt_msi_int == 32'd0 && n < 1200) begin
            if (msi.cfg_interrupt_msi_pending_status !== 32'h10) bad++;
            tick();
            n++;
        end
        check("tmo_held", bad, 0);
        check("tmo_delay", n, 1041);
        check("tmo_reissue", msi.cfg_interrupt_msi_int, 32'h10);
        ack_sent();
        check("tmo_clr", msi.cfg_interrupt_msi_pending_status, 32'd0);

        // Request on the current vector in the same cycle as sent keeps it pending.
        pulse_irq(12);
        expect_msi(32'h1000, "setwin_first");
        tick();
        msi.cfg_interrupt_msi_sent = 1'b1;
        irq_req                    = 32'h1000;
        tick();
        msi.cfg_interrupt_msi_sent = 1'b0;
        irq_req                    = '0;
        check("setwin_pend", msi.cfg_interrupt_msi_pending_status, 32'h1000);
        expect_msi(32'h1000, "setwin_reissue");
        ack_sent();
        check("setwin_clr", msi.cfg_interrupt_msi_pending_status, 32'd0);

        // Back-to-back requests for one vector coalesce into one MSI.
        irq_req = 32'h8;
        tick();
        tick();
        irq_req = '0;
        expect_msi(32'h8, "coal_first");
        ack_sent();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (msi.cfg_interrupt_msi_int != 32'd0) bad++;
            tick();
        end
        check("coal_single", bad, 0);
        check("coal_clr", msi.cfg_interrupt_msi_pending_status, 32'd0);

        // Enable dropped in WAIT: fail still goes through HOLD, then stall in IDLE.
        pulse_irq(2);
        expect_msi(32'h4, "endrop_first");
        tick();
        msi.cfg_interrupt_msi_enable = 4'h0;
        msi.cfg_interrupt_msi_fail   = 1'b1;
        tick();
        msi.cfg_interrupt_msi_fail   = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (msi.cfg_interrupt_msi_int != 32'd0) bad++;
            tick();
        end
        check("endrop_stall", bad, 0);
        check("endrop_pend", msi.cfg_interrupt_msi_pending_status, 32'h4);
        check("endrop_busy", busy, 0);
        msi.cfg_interrupt_msi_enable = 4'h1;
        expect_msi(32'h4, "endrop_resume");
        ack_sent();
        check("endrop_clr", msi.cfg_interrupt_msi_pending_status, 32'd0);

        // Enable gating then reset in WAIT.
        msi.cfg_interrupt_msi_enable = 4'h0;
        pulse_irq(0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (msi.cfg_interrupt_msi_int != 32'd0) bad++;
            tick();
        end
        check("gate_nomsi", bad, 0);
        check("gate_pend", msi.cfg_interrupt_msi_pending_status, 32'h1);
        check("gate_busy", busy, 0);
        msi.cfg_interrupt_msi_enable = 4'h1;
        expect_msi(32'h1, "gate_enabled");
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("rstwait_int", msi.cfg_interrupt_msi_int, 32'd0);
        check("rstwait_pend", msi.cfg_interrupt_msi_pending_status, 32'd0);
        check("rstwait_busy", busy, 0);
        irq_req = 32'h8;
        tick();
        tick();
        irq_req = '0;
        check("rst_irq_ignored", msi.cfg_interrupt_msi_pending_status, 32'd0);
        rst                        = 1'b0;
        msi.cfg_interrupt_msi_sent = 1'b1;
        tick();
        msi.cfg_interrupt_msi_sent = 1'b0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (msi.cfg_interrupt_msi_int != 32'd0 || busy) bad++;
            tick();
        end
        check("rstwait_noreissue", bad, 0);
        check("rstwait_pend_after", msi.cfg_interrupt_msi_pending_status, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pcie_msi_irq_gen.md
PCIE_MSI_IRQ_GEN -- requirements
Module: pcie_msi_irq_gen

Interface
REQ-001 SHALL have parameter IRQ_COUNT, default 32, meaning the number of MSI vectors (1..32).
REQ-002 SHALL have parameter RETRY_DELAY, default 16, meaning the holdoff cycles after a failed or timed-out MSI (1..255).
REQ-003 SHALL have parameter TIMEOUT, default 1024, meaning the cycles to wait for sent/fail before treating the request as failed (2..65535).
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-006 SHALL have port irq_req, input, IRQ_COUNT, one-cycle request pulses, one bit per vector.
REQ-007 SHALL have port cfg_interrupt_msi_enable, input, 4; only bit 0 (function 0) is used.
REQ-008 SHALL have port cfg_interrupt_msi_mmenable, input, 12; only bits 2:0 are used, as log2 of the enabled vector count.
REQ-009 SHALL have port cfg_interrupt_msi_int, output, 32, the one-hot MSI request pulse.
REQ-010 SHALL have port cfg_interrupt_msi_sent, input, 1, the completion strobe.
REQ-011 SHALL have port cfg_interrupt_msi_fail, input, 1, the failure strobe.
REQ-012 SHALL have port cfg_interrupt_msi_select, output, 4, tied to 0.
REQ-013 SHALL have port cfg_interrupt_msi_function_number, output, 4, tied to 0.
REQ-014 SHALL have port cfg_interrupt_msi_pending_status, output, 32, equal to the pending register zero-extended.
REQ-015 SHALL have port busy, output, 1, high when the state is not IDLE.

Function
REQ-016 SHALL hold a pending register (IRQ_COUNT bits); every cycle, pending |= irq_req.
REQ-017 SHALL map vector v to MSI bit (v & (2^mm - 1)), where mm = min(mmenable[2:0], 5); the pending register stays indexed by v.
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT and HOLD.
REQ-019 IDLE: if msi_enable[0]=1 and pending!=0, SHALL select a vector round-robin, starting at last_served+1 and wrapping IRQ_COUNT-1 to 0, latch it as cur, and go to ISSUE.
REQ-020 ISSUE: SHALL drive cfg_interrupt_msi_int one-hot at the mapped bit for exactly one cycle, then go to WAIT.
REQ-021 cfg_interrupt_msi_int SHALL be zero in every state other than ISSUE.
REQ-022 WAIT: on sent, SHALL clear pending[cur], set last_served=cur and go to IDLE.
REQ-023 If irq_req[cur] is asserted in the same cycle as sent, pending[cur] SHALL remain set (set wins).
REQ-024 WAIT: on fail, SHALL keep pending[cur] and go to HOLD; if sent and fail assert together, fail takes priority.
REQ-025 WAIT: after TIMEOUT cycles with neither strobe, SHALL behave as on fail.
REQ-026 HOLD: SHALL count RETRY_DELAY cycles, then go to IDLE; last_served is not updated, so the same vector wins again if still pending.
REQ-027 SHALL coalesce repeated requests for a pending vector into a single MSI.
REQ-028 SHALL ignore sent/fail strobes outside WAIT.
REQ-029 A drop of msi_enable[0] during WAIT or HOLD SHALL NOT abort the current request; the block returns to IDLE and stalls there while enable=0, keeping pending.
REQ-030 Minimum latency SHALL be 2 cycles, from an irq_req cycle (IDLE, enable=1) to the cfg_interrupt_msi_int pulse.
REQ-031 The timeout counter SHALL be 16 bits and the holdoff counter 8 bits; both SHALL load when their state is entered.

Reset
REQ-032 On rst, SHALL asynchronously set: pending=0, state=IDLE, last_served=IRQ_COUNT-1 (first search starts at vector 0), counters=0, cfg_interrupt_msi_int=0, busy=0, pending_status=0.
REQ-033 Assertion of rst mid-WAIT SHALL discard the outstanding request without a retry after deassertion; sent/fail arriving after reset SHALL be ignored.
REQ-034 irq_req SHALL be ignored while rst is high.

Verification
REQ-035 Single request: enable=1, mm=5, irq_req[3] pulse -> cfg_interrupt_msi_int=0x8 for one cycle, 2 cycles later; sent -> pending=0, busy=0.
REQ-036 Round-robin: pending bits 1, 2 and 5 set together, each acknowledged by sent -> issue order 1, 2, 5; new bit 0 then served after 5.
REQ-037 Fail and retry: fail on vector 7 -> HOLD for 16 cycles, vector 7 reissued; sent -> cleared.
REQ-038 Timeout: no strobe for 1024 cycles -> HOLD, reissue; pending_status bit stays set throughout.
REQ-039 Vector folding: mm=1, irq_req[6] -> cfg_interrupt_msi_int=0x1 (6&1=0); mm=2 -> 0x4.
REQ-040 Enable gating and reset: enable=0 with irq_req[0] -> no MSI, pending_status=0x1; enable=1 -> MSI issued; rst asserted in WAIT -> all outputs 0, no reissue.
